// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback over a shared memory port with a bounded
// wait on mem_ready, and traps bad opcodes / memory timeouts in FAULT.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StFault    = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // Keep at least one counter bit so TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  logic   [CntW-1:0] cnt_q, cnt_d;
  logic              wait_st;
  logic              expired;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and saturating wait counter.
  always_comb begin
    state_d = state_q;
    wait_st = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    // mem_ready in the same cycle always beats the timeout.
    expired = (TIMEOUT != 0) && !mem_ready && (cnt_q == CntLast);
    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (expired) state_d = StFault;
      end
      StDecode: begin
        unique case (opcode)
          OpRtype:     state_d = StExecute;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq:       state_d = StBranch;
          OpAddi:      state_d = StAddiExec;
          OpJ:         state_d = StJump;
          default:     state_d = StFault;
        endcase
      end
      StMemAddr:  state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (mem_ready)    state_d = StMemWb;
        else if (expired) state_d = StFault;
      end
      StMemWb:    state_d = StFetch;
      StMemWrite: begin
        if (mem_ready)    state_d = StFetch;
        else if (expired) state_d = StFault;
      end
      StExecute:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      StFault:    state_d = StFault;
      default:    state_d = StFault;
    endcase

    if (!wait_st || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (!mem_ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the current state; write strobes are blocked during reset.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    fault      = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      StDecode:   alu_src_b = 2'b11;
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRead: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      StJump: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb:   reg_write = 1'b1;
      StFault:    fault = 1'b1;
      default:    fault = 1'b1;
    endcase

    if (!rst_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver walks instructions through
// their phases, pushing the per-cycle expected state/controls; a monitor pops
// and compares on every falling edge.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, fault;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       fault;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  ctl_t got;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign got = '{pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, fault};

  // Control word each state must present, straight from the state table.
  function automatic ctl_t spec_ctl(input int st, input logic rdy, input logic z,
                                    input logic rst_low);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_en = rdy; c.ir_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
      9:  begin c.pc_src = 2'b10; c.pc_en = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: c.reg_write = 1;
      15: c.fault = 1;
      default: c = '0;
    endcase
    if (rst_low) begin
      c.pc_en = 0; c.ir_write = 0; c.reg_write = 0; c.mem_write = 0;
    end
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Apply one cycle of inputs and record what the DUT must show during it.
  task automatic cyc(input int st, input logic rdy, input logic z, input logic rst_low);
    exp_t e;
    rst_n     = !rst_low;
    mem_ready = rdy;
    zero      = z;
    e.st      = rst_low ? 4'd0 : 4'(st);
    e.ctl     = spec_ctl(rst_low ? 0 : st, rdy, z, rst_low);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Memory wait: 'waits' idle cycles then ready; TO idle cycles trap; abort_at resets.
  // status: 0 completed, 1 timed out into FAULT, 2 aborted by reset.
  task automatic mem_phase(input int st, input int waits, input int abort_at,
                           output int status);
    status = 0;
    for (int i = 0; i <= waits; i++) begin
      if (i == abort_at) begin
        cyc(0, rnd(), rnd(), 1'b1);
        status = 2;
        return;
      end
      if (i == waits) begin
        cyc(st, 1'b1, rnd(), 1'b0);
        return;
      end
      cyc(st, 1'b0, rnd(), 1'b0);
      if (i == TO - 1) begin
        status = 1;
        return;
      end
    end
  endtask

  // Sit in FAULT with arbitrary inputs, then leave it only through reset.
  task automatic fault_phase(input int n);
    for (int i = 0; i < n; i++) cyc(15, rnd(), rnd(), 1'b0);
    cyc(0, rnd(), rnd(), 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, input logic z,
                           input int abort_at);
    int s;
    opcode = opc;
    mem_phase(0, fw, -1, s);
    if (s == 1) fault_phase($urandom_range(1, 6));
    if (s != 0) return;
    cyc(1, rnd(), rnd(), 1'b0);
    case (opc)
      6'b000000: begin cyc(6, rnd(), rnd(), 1'b0); cyc(7, rnd(), rnd(), 1'b0); end
      6'b001000: begin cyc(10, rnd(), rnd(), 1'b0); cyc(11, rnd(), rnd(), 1'b0); end
      6'b100011: begin
        cyc(2, rnd(), rnd(), 1'b0);
        mem_phase(3, mw, abort_at, s);
        if (s == 1) fault_phase($urandom_range(1, 6));
        if (s == 0) cyc(4, rnd(), rnd(), 1'b0);
      end
      6'b101011: begin
        cyc(2, rnd(), rnd(), 1'b0);
        mem_phase(5, mw, abort_at, s);
        if (s == 1) fault_phase($urandom_range(1, 6));
      end
      6'b000100: cyc(8, rnd(), z, 1'b0);
      6'b000010: cyc(9, rnd(), rnd(), 1'b0);
      default:   fault_phase(20);
    endcase
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 11) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
  endfunction

  // Monitor: compare every cycle against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (state !== e.st) begin
          n_bad++;
          $display("FAIL state t=%0t got %0d want %0d", $time, state, e.st);
        end
        n_cmp++;
        if (got !== e.ctl) begin
          n_bad++;
          $display("FAIL ctl st=%0d t=%0t got %h want %h", e.st, $time, got, e.ctl);
        end
      end
    end
  end

  // Driver: directed scenarios first, then randomized instruction stream.
  initial begin
    logic [5:0] ops [6];
    logic [5:0] opc;
    int mw;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    @(posedge clk);
    #1;
    cyc(0, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b1);

    run_instr(6'b000000, 0, 0, 1'b0, -1);  // R-type
    run_instr(6'b100011, 0, 2, 1'b0, -1);  // lw, 2 idle cycles in MEM_READ
    run_instr(6'b000100, 0, 0, 1'b1, -1);  // beq taken
    run_instr(6'b000100, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(6'b111111, 0, 0, 1'b0, -1);  // illegal opcode -> FAULT, then reset
    run_instr(6'b101011, 0, 4, 1'b0, -1);  // sw timeout
    run_instr(6'b101011, 0, 3, 1'b0, -1);  // sw ready on the last allowed cycle
    run_instr(6'b101011, 1, 3, 1'b0, 1);   // reset mid MEM_WRITE
    run_instr(6'b001000, 3, 0, 1'b0, -1);  // addi, fetch ready on last allowed cycle
    run_instr(6'b000010, 4, 0, 1'b0, -1);  // fetch timeout
    run_instr(6'b000010, 0, 0, 1'b0, -1);  // j

    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 6);
      opc = (k == 6) ? 6'($urandom) : ops[k];
      mw = pick_wait();
      run_instr(opc, pick_wait(), mw, rnd(),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, mw)) : -1);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
